// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU load/store memory responder.
package mem_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam int unsigned LED_OFF = 32'h0;
  localparam int unsigned SW_OFF  = 32'h4;
  localparam int unsigned BTN_OFF = 32'h8;

  // Address bit that separates RAM (0) from the MMIO window (1).
  function automatic int unsigned region_bit(int unsigned addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request and response channel between the CPU and the memory responder.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module mem_bram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 12
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int unsigned BeW = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BeW; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, decoded to byte-enabled RAM or an MMIO window
// (LED/SW/BTN). Define BTN_EDGE_EN to make BTN reads return sticky rising-edge flags.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned READ_LAT = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  mem_responder_if.slave mem_if,
  input  logic [3:0]     sw_i,
  input  logic [3:0]     btn_i,
  output logic [3:0]     led_o
);
  localparam int unsigned WordW     = ADDR_W - 3;
  localparam int unsigned OffW      = ADDR_W - 1;
  localparam int unsigned RegionBit = region_bit(ADDR_W);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              alive_q;
  logic              we_q, err_q, mmio_q;
  logic [3:0]        mmio_rdata_q, mmio_rdata_d;
  logic [3:0]        led_q, led_d;
  logic [3:0]        sw_s1_q, sw_s2_q, btn_s1_q, btn_s2_q;
  logic [3:0]        btn_val;

  logic              accept, misaligned, is_mmio, off_led, off_sw, off_btn, mmio_bad, req_err;
  logic [OffW-1:0]   off;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign accept     = mem_if.req_valid && mem_if.req_ready;
  assign misaligned = mem_if.req_addr[1:0] != 2'b00;
  assign is_mmio    = mem_if.req_addr[RegionBit];
  assign off        = mem_if.req_addr[OffW-1:0];
  assign off_led    = off == OffW'(LED_OFF);
  assign off_sw     = off == OffW'(SW_OFF);
  assign off_btn    = off == OffW'(BTN_OFF);
  // Unknown offsets and stores to read-only registers both fault.
  assign mmio_bad   = !(off_led || off_sw || off_btn) || (mem_if.req_we && !off_led);
  assign req_err    = misaligned || (is_mmio && mmio_bad);
  assign ram_en     = accept && !is_mmio && !misaligned;

  mem_bram #(
    .DATA_W (DATA_W),
    .AW     (WordW)
  ) u_bram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (mem_if.req_we),
    .be_i    (mem_if.req_be),
    .addr_i  (mem_if.req_addr[ADDR_W-2:2]),
    .wdata_i (mem_if.req_wdata),
    .rdata_o (ram_rdata)
  );

`ifdef BTN_EDGE_EN
  logic [3:0] btn_prev_q, btn_flag_q, btn_flag_d;
  logic       btn_clr;

  // A rise landing on the clearing read's edge survives the clear.
  assign btn_clr    = accept && !mem_if.req_we && is_mmio && !misaligned && off_btn;
  assign btn_flag_d = (btn_flag_q & ~{4{btn_clr}}) | (btn_s2_q & ~btn_prev_q);
  assign btn_val    = btn_flag_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_prev_q <= '0;
      btn_flag_q <= '0;
    end else begin
      btn_prev_q <= btn_s2_q;
      btn_flag_q <= btn_flag_d;
    end
  end
`else
  assign btn_val = btn_s2_q;
`endif

  always_comb begin
    mmio_rdata_d = led_q;
    if (off_sw) mmio_rdata_d = sw_s2_q;
    else if (off_btn) mmio_rdata_d = btn_val;

    led_d = led_q;
    if (accept && mem_if.req_we && is_mmio && !misaligned && off_led && mem_if.req_be[0]) begin
      led_d = mem_if.req_wdata[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 3'd1;
          state_d = (READ_LAT == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'(READ_LAT - 1)) state_d = StResp;
        else cnt_d = cnt_q + 3'd1;
      end
      StResp: begin
        if (mem_if.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alive_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mmio_q       <= 1'b0;
      mmio_rdata_q <= '0;
      led_q        <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
      if (accept) begin
        we_q         <= mem_if.req_we;
        err_q        <= req_err;
        mmio_q       <= is_mmio;
        mmio_rdata_q <= mmio_rdata_d;
      end
      led_q    <= led_d;
      sw_s1_q  <= sw_i;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_i;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Ready is held low for the first edge after reset release.
  assign mem_if.req_ready = (state_q == StIdle) && alive_q;
  assign mem_if.rsp_valid = state_q == StResp;
  assign mem_if.rsp_err   = mem_if.rsp_valid && err_q;
  assign mem_if.rsp_rdata = (mem_if.rsp_valid && !err_q && !we_q) ?
                            (mmio_q ? {{(DATA_W-4){1'b0}}, mmio_rdata_q} : ram_rdata) : '0;
  assign led_o = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, multi-cycle sequences, random vs model.
module tb_mem_responder;
  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] sw = 4'b1010;
  logic [3:0] btn = 4'b0000;
  logic [3:0] led3, led1;

  int checks = 0;
  int errors = 0;

  mem_responder_if #(.DATA_W(32), .ADDR_W(15)) bus3 ();
  mem_responder_if #(.DATA_W(32), .ADDR_W(15)) bus1 ();

  mem_responder #(.DATA_W(32), .ADDR_W(15), .READ_LAT(LAT)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .mem_if (bus3.slave),
    .sw_i   (sw),
    .btn_i  (btn),
    .led_o  (led3)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(15), .READ_LAT(1)) dut1 (
    .clk    (clk),
    .n_rst  (n_rst),
    .mem_if (bus1.slave),
    .sw_i   (sw),
    .btn_i  (btn),
    .led_o  (led1)
  );

  always #5 clk = ~clk;

  // Reference state for the random phase.
  logic [31:0] ram_m [4096];
  logic [3:0]  led_m, sw_m, btn_m, btn_flag_m;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int unsigned hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [14:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
    rd = '0;
    er = 1'b0;
    if (a[1:0] != 2'b00) begin
      er = 1'b1;
    end else if (!a[14]) begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) ram_m[a[13:2]][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = ram_m[a[13:2]];
      end
    end else begin
      case (a[13:0])
        14'h0: if (we) begin if (be[0]) led_m = wd[3:0]; end else rd = {28'h0, led_m};
        14'h4: if (we) er = 1'b1; else rd = {28'h0, sw_m};
        14'h8: begin
          if (we) er = 1'b1;
          else begin
`ifdef BTN_EDGE_EN
            rd = {28'h0, btn_flag_m};
            btn_flag_m = '0;
`else
            rd = {28'h0, btn_m};
`endif
          end
        end
        default: er = 1'b1;
      endcase
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [14:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input int unsigned hold,
                      input logic [31:0] exp_rd, input logic exp_er);
    int n;
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_addr  = a;
    bus3.req_wdata = wd;
    bus3.req_be    = be;
    n = 0;
    while (bus3.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk({tag, " accept_timeout"}, 32'h0, 32'h1);
      bus3.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Request fields are scrambled after acceptance; the DUT must have latched them.
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'($urandom);
    bus3.req_addr  = 15'($urandom);
    bus3.req_wdata = $urandom;
    bus3.req_be    = 4'($urandom);
    n = 1;
    while (bus3.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    repeat (hold) begin
      chk({tag, " hold_valid"}, 32'(bus3.rsp_valid), 32'h1);
      chk({tag, " hold_rdata"}, bus3.rsp_rdata, exp_rd);
      chk({tag, " hold_req_ready"}, 32'(bus3.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    chk({tag, " rdata"}, bus3.rsp_rdata, exp_rd);
    chk({tag, " err"}, 32'(bus3.rsp_err), 32'(exp_er));
    chk({tag, " busy_req_ready"}, 32'(bus3.req_ready), 32'h0);
    bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.rsp_ready = 1'b0;
    chk({tag, " rsp_drop"}, 32'(bus3.rsp_valid), 32'h0);
    chk({tag, " ready_again"}, 32'(bus3.req_ready), 32'h1);
  endtask

  task automatic xact1(input string tag, input logic we, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
    int n;
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = 15'h0010;
    bus1.req_wdata = wd;
    bus1.req_be    = 4'hF;
    n = 0;
    while (bus1.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " accept"}, 32'(n < 50), 32'h1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk({tag, " lat1_valid"}, 32'(bus1.rsp_valid), 32'h1);
    chk({tag, " rdata"}, bus1.rsp_rdata, exp_rd);
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
    chk({tag, " rsp_drop"}, 32'(bus1.rsp_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eer;
    logic [14:0] a;
    int          r;
    bit          stray;

    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
    bus3.req_wdata = '0;   bus3.req_be = '0;   bus3.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_be = '0;   bus1.rsp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst req_ready", 32'(bus3.req_ready), 32'h0);
    chk("rst rsp_valid", 32'(bus3.rsp_valid), 32'h0);
    chk("rst rsp_rdata", bus3.rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(bus3.rsp_err), 32'h0);
    chk("rst led", 32'(led3), 32'h0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    chk("release req_ready_low", 32'(bus3.req_ready), 32'h0);
    @(posedge clk); #1;
    chk("release req_ready_high", 32'(bus3.req_ready), 32'h1);
    repeat (3) @(posedge clk); #1;

    // Directed table
    tbl.push_back('{1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h0010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 15'h0010, 32'h000000AA, 4'h1, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h0010, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0});
    tbl.push_back('{1'b0, 15'h0012, 32'h0,        4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 15'h0012, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 15'h0010, 32'h0,        4'h0, 5, 32'hDEADBEAA, 1'b0});
    tbl.push_back('{1'b1, 15'h0020, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 15'h0020, 32'h11111111, 4'h0, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 15'h0020, 32'hAABBCCDD, 4'h6, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h0020, 32'h0,        4'h0, 1, 32'hCABBCC0D, 1'b0});
    tbl.push_back('{1'b1, 15'h3FFC, 32'h0BADF00D, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h3FFC, 32'h0,        4'h0, 0, 32'h0BADF00D, 1'b0});
    tbl.push_back('{1'b1, 15'h4000, 32'h00000005, 4'hF, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h4000, 32'h0,        4'h0, 0, 32'h00000005, 1'b0});
    tbl.push_back('{1'b0, 15'h4004, 32'h0,        4'h0, 0, 32'h0000000A, 1'b0});
    tbl.push_back('{1'b1, 15'h4004, 32'h0000000F, 4'hF, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 15'h400C, 32'h0,        4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 15'h4008, 32'h0000000F, 4'hF, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 15'h4002, 32'h0,        4'h0, 0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 15'h4008, 32'h0,        4'h0, 0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 15'h4010, 32'h0,        4'h0, 0, 32'h0,        1'b1});
    foreach (tbl[i]) begin
      xact($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
           tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_er);
    end
    chk("led after store", 32'(led3), 32'h5);

    // Button: sticky edge flag or level
`ifdef BTN_EDGE_EN
    btn = 4'b0100;
    repeat (3) @(posedge clk); #1;
    btn = 4'b0000;
    repeat (4) @(posedge clk); #1;
    xact("btn edge first", 1'b0, 15'h4008, 32'h0, 4'h0, 0, 32'h4, 1'b0);
    xact("btn edge second", 1'b0, 15'h4008, 32'h0, 4'h0, 0, 32'h0, 1'b0);
`else
    btn = 4'b0100;
    repeat (3) @(posedge clk); #1;
    xact("btn level first", 1'b0, 15'h4008, 32'h0, 4'h0, 0, 32'h4, 1'b0);
    xact("btn level second", 1'b0, 15'h4008, 32'h0, 4'h0, 0, 32'h4, 1'b0);
    btn = 4'b0000;
    repeat (3) @(posedge clk); #1;
`endif

    // Reset in the middle of WAIT
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 15'h0010;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(bus3.rsp_valid), 32'h0);
    chk("midrst led", 32'(led3), 32'h0);
    chk("midrst req_ready", 32'(bus3.req_ready), 32'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("midrst release ready_low", 32'(bus3.req_ready), 32'h0);
    @(posedge clk); #1;
    chk("midrst release ready_high", 32'(bus3.req_ready), 32'h1);
    stray = 1'b0;
    repeat (5) begin
      if (bus3.rsp_valid !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst no stray rsp", 32'(stray), 32'h0);
    xact("ram kept over reset", 1'b0, 15'h0010, 32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0);

    // READ_LAT=1 instance
    xact1("lat1 store", 1'b1, 32'hDEADBEEF, 32'h0);
    xact1("lat1 load", 1'b0, 32'h0, 32'hDEADBEEF);

    // Random traffic against the model
    led_m = 4'h0; sw_m = sw; btn_m = btn; btn_flag_m = 4'h0;
    for (int i = 0; i < 16; i++) begin
      a = 15'(32'h100 + 4 * i);
      erd = $urandom;
      model(1'b1, a, erd, 4'hF, erd, eer);
      xact($sformatf("init%0d", i), 1'b1, a, ram_m[a[13:2]], 4'hF, 0, erd, eer);
    end
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] wd;
      logic [3:0]  be;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        sw = 4'($urandom);
        sw_m = sw;
        repeat (3) @(posedge clk); #1;
      end
      if (r < 7) begin
        a = 15'(32'h100 + 4 * $urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 4))
          0: a = 15'h4000;
          1: a = 15'h4004;
          2: a = 15'h4008;
          3: a = 15'h400C;
          default: a = 15'(32'h4000 | ($urandom & 32'h3FFF));
        endcase
      end
      we = 1'($urandom);
      wd = $urandom;
      be = 4'($urandom);
      model(we, a, wd, be, erd, eer);
      xact($sformatf("rnd%0d", i), we, a, wd, be, $urandom_range(0, 2), erd, eer);
      chk($sformatf("rnd%0d led", i), 32'(led3), 32'(led_m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
